// File: rtl/secure_capture_pkg.sv
// Shared types, default sizes and pointer helper for the secure capture buffer.
package secure_capture_pkg;

    localparam int unsigned CAP_DEPTH = 8;
    localparam int unsigned CAP_DW    = 32;

    // One captured word with the secure tag sitting above the data bits.
    typedef struct packed {
        logic              secure;
        logic [CAP_DW-1:0] data;
    } cap_entry_t;

    // Advance a circular pointer, wrapping at depth.
    function automatic int unsigned ptr_next(input int unsigned ptr, input int unsigned depth);
        return (ptr + 1) % depth;
    endfunction

endpackage

// File: rtl/sc_fifo_mem.sv
// Register-array storage for the capture FIFO: one write port, one registered
// read port, plus a combinational look at the head entry's tag so the top can
// judge privilege in the same cycle the pop is accepted.
module sc_fifo_mem #(
    parameter  int unsigned DEPTH = 8,
    parameter  int unsigned W     = 33,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata,
    output logic          head_tag
);

    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] mem_d [DEPTH];
    logic [W-1:0] rdata_q;
    logic [W-1:0] rdata_d;

    // Next storage contents: only the addressed entry changes on a write.
    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[waddr] = wdata;
        end
    end

    // Storage array; contents are not cleared by reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Read register loads only on a pop and otherwise holds the last word.
    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem_q[raddr];
        end
    end

    // Read register; cleared so the reader sees zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata    = rdata_q;
    assign head_tag = mem_q[raddr][W-1];

endmodule

// File: rtl/secure_capture_buf.sv
// Secure capture buffer: stores strobed {secure, data} words from the secure
// source in a small FIFO and returns them over a one-cycle-latency pop
// handshake, zeroing secure words popped by an unprivileged reader.
// Optional build macro: SEC_FLUSH_ON_VIOLATION_EN -- when defined, a
// privilege violation flushes the FIFO on the following cycle.
module secure_capture_buf
    import secure_capture_pkg::*;
#(
    parameter int unsigned DEPTH = CAP_DEPTH,
    parameter int unsigned DW    = CAP_DW
) (
    input  logic                   clk,
    input  logic                   rst1,
    input  logic                   strobe,
    input  logic [DW-1:0]          data,
    input  logic                   secure_in,
    input  logic                   status_in,
    input  logic                   rd_req,
    input  logic                   rd_priv,
    input  logic                   clr_sticky,
    output logic                   rd_valid,
    output logic [DW-1:0]          rd_data,
    output logic                   rd_secure,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty,
    output logic                   overflow,
    output logic                   sec_violation
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef struct packed {
        logic          secure;
        logic [DW-1:0] data;
    } entry_t;

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;
    logic          rd_valid_q, rd_valid_d;
    logic          deny_q, deny_d;
    logic          overflow_q, overflow_d;
    logic          sec_viol_q, sec_viol_d;

    logic          flush;
    logic          pop;
    logic          push;
    logic          drop;
    logic          violate;
    logic          head_tag;
    entry_t        wr_entry;
    entry_t        rd_entry;

`ifdef SEC_FLUSH_ON_VIOLATION_EN
    logic flush_q, flush_d;
`endif

    sc_fifo_mem #(
        .DEPTH (DEPTH),
        .W     (DW + 1)
    ) u_mem (
        .clk      (clk),
        .rst_n    (rst1),
        .we       (push),
        .waddr    (wr_ptr_q),
        .wdata    (wr_entry),
        .re       (pop),
        .raddr    (rd_ptr_q),
        .rdata    (rd_entry),
        .head_tag (head_tag)
    );

    // Classify this cycle's write/pop events; a flush cycle swallows both.
    always_comb begin
`ifdef SEC_FLUSH_ON_VIOLATION_EN
        flush = flush_q;
`else
        flush = 1'b0;
`endif
        wr_entry.secure = secure_in;
        wr_entry.data   = data;
        pop     = rd_req & ~empty_q & ~flush;
        // A pop in the same cycle frees the slot, so a full FIFO still accepts.
        push    = strobe & status_in & (~full_q | pop) & ~flush;
        drop    = strobe & status_in & full_q & ~pop & ~flush;
        violate = pop & head_tag & ~rd_priv;
    end

    // Pointer, occupancy and status-flag next state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = AW'(ptr_next(32'(wr_ptr_q), DEPTH));
        end
        if (pop) begin
            rd_ptr_d = AW'(ptr_next(32'(rd_ptr_q), DEPTH));
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
        full_d  = (count_d == CW'(DEPTH));
        empty_d = (count_d == '0);
    end

    // Read handshake and sticky flags; a setting event beats a clear.
    always_comb begin
        rd_valid_d = pop;
        deny_d     = pop ? (head_tag & ~rd_priv) : deny_q;
        overflow_d = drop | (overflow_q & ~clr_sticky);
        sec_viol_d = violate | (sec_viol_q & ~clr_sticky);
    end

`ifdef SEC_FLUSH_ON_VIOLATION_EN
    // Flush is scheduled for the cycle after a violating pop.
    always_comb begin
        flush_d = violate;
    end

    // Flush request register.
    always_ff @(posedge clk or negedge rst1) begin
        if (!rst1) begin
            flush_q <= 1'b0;
        end else begin
            flush_q <= flush_d;
        end
    end
`endif

    // Control state registers.
    always_ff @(posedge clk or negedge rst1) begin
        if (!rst1) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            rd_valid_q <= 1'b0;
            deny_q     <= 1'b0;
            overflow_q <= 1'b0;
            sec_viol_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            rd_valid_q <= rd_valid_d;
            deny_q     <= deny_d;
            overflow_q <= overflow_d;
            sec_viol_q <= sec_viol_d;
        end
    end

    // Output mapping; denied words read back as zero while the tag stays visible.
    always_comb begin
        rd_valid      = rd_valid_q;
        rd_data       = deny_q ? '0 : rd_entry.data;
        rd_secure     = rd_entry.secure;
        count         = count_q;
        full          = full_q;
        empty         = empty_q;
        overflow      = overflow_q;
        sec_violation = sec_viol_q;
    end

endmodule

// File: tb/tb_secure_capture_buf.sv
// Directed, table-driven bench for secure_capture_buf (DEPTH=8, DW=32).
module tb_secure_capture_buf;

    logic        clk;
    logic        rst1;
    logic        strobe;
    logic [31:0] data;
    logic        secure_in;
    logic        status_in;
    logic        rd_req;
    logic        rd_priv;
    logic        clr_sticky;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic        rd_secure;
    logic [3:0]  count;
    logic        full;
    logic        empty;
    logic        overflow;
    logic        sec_violation;

    int checks   = 0;
    int failures = 0;

    secure_capture_buf #(
        .DEPTH (8),
        .DW    (32)
    ) dut (
        .clk           (clk),
        .rst1          (rst1),
        .strobe        (strobe),
        .data          (data),
        .secure_in     (secure_in),
        .status_in     (status_in),
        .rd_req        (rd_req),
        .rd_priv       (rd_priv),
        .clr_sticky    (clr_sticky),
        .rd_valid      (rd_valid),
        .rd_data       (rd_data),
        .rd_secure     (rd_secure),
        .count         (count),
        .full          (full),
        .empty         (empty),
        .overflow      (overflow),
        .sec_violation (sec_violation)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          stb;
        logic [31:0] d;
        bit          sec;
        bit          st;
        bit          rq;
        bit          pr;
        bit          clr;
        bit          ev;
        logic [31:0] ed;
        bit          es;
        int          ec;
        bit          ef;
        bit          ee;
        bit          eo;
        bit          esv;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(bit stb, logic [31:0] d, bit sec, bit st, bit rq, bit pr, bit clr,
                               bit ev, logic [31:0] ed, bit es, int ec, bit ef, bit ee, bit eo, bit esv);
        vec_t t;
        t.stb = stb; t.d = d; t.sec = sec; t.st = st; t.rq = rq; t.pr = pr; t.clr = clr;
        t.ev = ev; t.ed = ed; t.es = es; t.ec = ec; t.ef = ef; t.ee = ee; t.eo = eo; t.esv = esv;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input bit ev, input logic [31:0] ed, input bit es,
                           input int ec, input bit ef, input bit ee, input bit eo, input bit esv);
        chk({tag, "_rd_valid"}, 32'(rd_valid), 32'(ev));
        chk({tag, "_rd_data"}, rd_data, ed);
        chk({tag, "_rd_secure"}, 32'(rd_secure), 32'(es));
        chk({tag, "_count"}, 32'(count), ec);
        chk({tag, "_full"}, 32'(full), 32'(ef));
        chk({tag, "_empty"}, 32'(empty), 32'(ee));
        chk({tag, "_overflow"}, 32'(overflow), 32'(eo));
        chk({tag, "_sec_violation"}, 32'(sec_violation), 32'(esv));
    endtask

    // Drive one cycle of inputs, clock it, and settle just past the edge.
    task automatic step(input bit stb, input logic [31:0] d, input bit sec, input bit st,
                        input bit rq, input bit pr, input bit clr);
        strobe = stb; data = d; secure_in = sec; status_in = st;
        rd_req = rq; rd_priv = pr; clr_sticky = clr;
        @(posedge clk);
        #1;
        strobe = 1'b0; rd_req = 1'b0; clr_sticky = 1'b0;
    endtask

    initial begin
        // stb data sec st rq pr clr | ev data sec count full empty ovf sv
        vecs.push_back(v(1, 32'h11, 0, 1, 0, 0, 0,  0, 32'h0, 0, 1, 0, 0, 0, 0));
        vecs.push_back(v(1, 32'h22, 0, 1, 0, 0, 0,  0, 32'h0, 0, 2, 0, 0, 0, 0));
        vecs.push_back(v(1, 32'h33, 0, 1, 0, 0, 0,  0, 32'h0, 0, 3, 0, 0, 0, 0));
        vecs.push_back(v(0, 32'h0, 0, 1, 1, 0, 0,   1, 32'h11, 0, 2, 0, 0, 0, 0));
        vecs.push_back(v(0, 32'h0, 0, 1, 1, 0, 0,   1, 32'h22, 0, 1, 0, 0, 0, 0));
        vecs.push_back(v(0, 32'h0, 0, 1, 1, 0, 0,   1, 32'h33, 0, 0, 0, 1, 0, 0));
        vecs.push_back(v(0, 32'h0, 0, 1, 0, 0, 0,   0, 32'h33, 0, 0, 0, 1, 0, 0));
        vecs.push_back(v(0, 32'h0, 0, 1, 1, 0, 0,   0, 32'h33, 0, 0, 0, 1, 0, 0));
        vecs.push_back(v(1, 32'h99, 0, 0, 0, 0, 0,  0, 32'h33, 0, 0, 0, 1, 0, 0));
        vecs.push_back(v(1, 32'hDEADBEEF, 1, 1, 0, 0, 0, 0, 32'h33, 0, 1, 0, 0, 0, 0));
        vecs.push_back(v(0, 32'h0, 0, 1, 1, 0, 0,   1, 32'h0, 1, 0, 0, 1, 0, 1));
        vecs.push_back(v(0, 32'h0, 0, 1, 0, 0, 0,   0, 32'h0, 1, 0, 0, 1, 0, 1));
        vecs.push_back(v(1, 32'hDEADBEEF, 1, 1, 0, 0, 0, 0, 32'h0, 1, 1, 0, 0, 0, 1));
        vecs.push_back(v(0, 32'h0, 0, 1, 1, 1, 0,   1, 32'hDEADBEEF, 1, 0, 0, 1, 0, 1));
        vecs.push_back(v(0, 32'h0, 0, 1, 0, 0, 1,   0, 32'hDEADBEEF, 1, 0, 0, 1, 0, 0));
        vecs.push_back(v(1, 32'h5, 1, 1, 0, 0, 0,   0, 32'hDEADBEEF, 1, 1, 0, 0, 0, 0));
        vecs.push_back(v(0, 32'h0, 0, 1, 1, 0, 1,   1, 32'h0, 1, 0, 0, 1, 0, 1));
        vecs.push_back(v(0, 32'h0, 0, 1, 0, 0, 0,   0, 32'h0, 1, 0, 0, 1, 0, 1));
        vecs.push_back(v(0, 32'h0, 0, 1, 0, 0, 1,   0, 32'h0, 1, 0, 0, 1, 0, 0));
        vecs.push_back(v(1, 32'h55, 0, 1, 1, 0, 0,  0, 32'h0, 1, 1, 0, 0, 0, 0));
        vecs.push_back(v(0, 32'h0, 0, 1, 1, 0, 0,   1, 32'h55, 0, 0, 0, 1, 0, 0));

        rst1 = 1'b0; strobe = 1'b0; data = '0; secure_in = 1'b0; status_in = 1'b0;
        rd_req = 1'b0; rd_priv = 1'b0; clr_sticky = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 0, 32'h0, 0, 0, 0, 1, 0, 0);
        @(negedge clk);
        rst1 = 1'b1;
        @(posedge clk);
        #1;
        chk_all("post_reset", 0, 32'h0, 0, 0, 0, 1, 0, 0);

        foreach (vecs[i]) begin
            step(vecs[i].stb, vecs[i].d, vecs[i].sec, vecs[i].st, vecs[i].rq, vecs[i].pr, vecs[i].clr);
            chk_all($sformatf("row%0d", i), vecs[i].ev, vecs[i].ed, vecs[i].es, vecs[i].ec,
                    vecs[i].ef, vecs[i].ee, vecs[i].eo, vecs[i].esv);
        end

        // Fill past capacity: the ninth word is dropped and flags overflow.
        for (int i = 0; i < 9; i++) begin
            step(1, 32'hA0 + 32'(i), 0, 1, 0, 0, 0);
            chk($sformatf("fill%0d_count", i), 32'(count), (i < 8) ? i + 1 : 8);
            chk($sformatf("fill%0d_full", i), 32'(full), (i >= 7) ? 1 : 0);
            chk($sformatf("fill%0d_overflow", i), 32'(overflow), (i == 8) ? 1 : 0);
        end
        step(0, 32'h0, 0, 1, 0, 0, 1);
        chk("ovf_clear", 32'(overflow), 0);
        chk("ovf_clear_full", 32'(full), 1);
        // Write and pop together while full: both taken, no overflow.
        step(1, 32'h55, 0, 1, 1, 0, 0);
        chk_all("full_wr_pop", 1, 32'hA0, 0, 8, 1, 0, 0, 0);
        for (int i = 0; i < 7; i++) begin
            step(0, 32'h0, 0, 1, 1, 0, 0);
            chk($sformatf("drain%0d_data", i), rd_data, 32'hA1 + 32'(i));
            chk($sformatf("drain%0d_count", i), 32'(count), 7 - i);
        end
        step(0, 32'h0, 0, 1, 1, 0, 0);
        chk_all("drain_last", 1, 32'h55, 0, 0, 0, 1, 0, 0);

        // Asynchronous reset in the middle of a pop.
        for (int i = 0; i < 5; i++) step(1, 32'h60 + 32'(i), 0, 1, 0, 0, 0);
        step(1, 32'h66, 0, 1, 1, 0, 0);
        chk_all("pre_rst", 1, 32'h60, 0, 5, 0, 0, 0, 0);
        #2;
        rst1 = 1'b0;
        #1;
        chk_all("async_rst", 0, 32'h0, 0, 0, 0, 1, 0, 0);
        @(negedge clk);
        rst1 = 1'b1;
        step(1, 32'h77, 0, 1, 0, 0, 0);
        chk("rst_wr_count", 32'(count), 1);
        step(0, 32'h0, 0, 1, 1, 0, 0);
        chk_all("rst_pop", 1, 32'h77, 0, 0, 0, 1, 0, 0);

        // Violating pop with entries still behind it.
        step(1, 32'h1, 1, 1, 0, 0, 0);
        step(1, 32'h2, 0, 1, 0, 0, 0);
        step(1, 32'h3, 0, 1, 0, 0, 0);
        step(1, 32'h4, 0, 1, 0, 0, 0);
        step(0, 32'h0, 0, 1, 1, 0, 0);
        chk_all("viol_pop", 1, 32'h0, 1, 3, 0, 0, 0, 1);
`ifdef SEC_FLUSH_ON_VIOLATION_EN
        step(1, 32'h88, 0, 1, 0, 0, 0);
        chk_all("flush", 0, 32'h0, 1, 0, 0, 1, 0, 1);
        step(0, 32'h0, 0, 1, 0, 0, 0);
        chk_all("post_flush", 0, 32'h0, 1, 0, 0, 1, 0, 1);
`else
        step(0, 32'h0, 0, 1, 0, 0, 0);
        chk_all("no_flush", 0, 32'h0, 1, 3, 0, 0, 0, 1);
        step(0, 32'h0, 0, 1, 1, 0, 0);
        chk_all("after_viol", 1, 32'h2, 0, 2, 0, 0, 0, 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/secure_capture_buf.md
Name: secure_capture_buf

Overview:
- Downstream consumer of the secure data source block. Captures each strobed 32-bit word together with its secure tag into a small FIFO.
- Returns words to a reader over a valid/request handshake and enforces privilege on secure-tagged words.
- Sits between the secure source and the APB readback logic of the APB-to-I2C bridge.

Parameters:
- DEPTH, 8, number of FIFO entries; power of two, range 2..64.
- DW, 32, data word width; must equal the source's data width.

Ports:
- clk  in  1  single clock, rising edge.
- rst1  in  1  asynchronous active-low reset.
- strobe  in  1  source word-valid pulse, one word per high cycle.
- data  in  DW  source data, sampled when strobe=1.
- secure_in  in  1  secure tag from the source's secure_out, sampled with data.
- status_in  in  1  source status; capture is enabled only while 1.
- rd_req  in  1  reader pop request.
- rd_priv  in  1  reader is privileged; sampled with rd_req.
- clr_sticky  in  1  clears the overflow and sec_violation flags.
- rd_valid  out  1  rd_data/rd_secure valid; one-cycle pulse.
- rd_data  out  DW  popped word, or 0 if access is denied.
- rd_secure  out  1  tag of the popped entry.
- count  out  $clog2(DEPTH)+1  current occupancy.
- full  out  1  count==DEPTH.
- empty  out  1  count==0.
- overflow  out  1  sticky: a strobe was dropped.
- sec_violation  out  1  sticky: an unprivileged pop hit a secure entry.

Behaviour:
- Reset (rst1=0, async): wr/rd pointers=0, count=0, empty=1, full=0, rd_valid=0, rd_data=0, rd_secure=0, overflow=0, sec_violation=0. Storage contents need not be cleared.
- Reset asserted mid-operation aborts any in-flight pop; rd_valid drops immediately.
- Write: strobe&status_in&!full at edge -> entry {secure_in,data} stored at wr_ptr, wr_ptr++ (wraps mod DEPTH), count++.
- strobe&!status_in -> word ignored silently; no overflow.
- strobe&status_in&full&!pop -> word dropped, overflow<=1.
- Pop: rd_req&!empty at edge -> rd_ptr++, count--. Next cycle rd_valid=1 with rd_secure=entry tag. Latency is 1 cycle.
- Pop with entry.secure=1 and rd_priv=0 -> rd_data=0, sec_violation<=1. The entry is still consumed.
- Otherwise rd_data=entry data.
- rd_req while empty -> no pop, rd_valid=0 next cycle, no error.
- Simultaneous write and pop:
  - Not empty: both occur, count unchanged.
  - Full: both accepted, no overflow.
  - Empty: write accepted, pop ignored; there is no bypass.
- rd_data/rd_secure hold their last value when rd_valid=0.
- clr_sticky clears both sticky flags. If a setting event occurs in the same cycle, the set wins.
- count, full and empty are registered and updated in the same cycle as the pointers.
- Source clock gating is tolerated: strobe is sampled on clk only, with no assumption about gaps between strobes.

Optional Feature:
- Macro: SEC_FLUSH_ON_VIOLATION_EN.
- Defined: the cycle after sec_violation is set by a pop, the FIFO flushes. Pointers and count go to 0 and empty=1. A strobe in the flush cycle is dropped without setting overflow.
- Undefined: no flush; remaining entries stay readable.

Decomposition:
- Package secure_capture_pkg:
  - typedef struct packed {logic secure; logic [DW-1:0] data;} cap_entry_t;
  - localparam defaults CAP_DEPTH=8, CAP_DW=32.
  - function for pointer wrap.
- Sub-module sc_fifo_mem: DEPTH x entry register array, one write port, registered read port.
- Top level holds the pointers, count, handshake, privilege check, sticky flags and flush.

Test Plan:
- Write three words, then pop them: strobe with data 0x11, 0x22, 0x33 (secure=0, status=1), then rd_req x3, rd_priv=0 -> rd_valid pulses one cycle after each req, rd_data 0x11/0x22/0x33 in order, count 3->0, empty=1.
- Overflow: 9 strobes of 0xA0+i with DEPTH=8 -> full=1 after 8, overflow=1, and popping 8 returns 0xA0..0xA7. Then clr_sticky -> overflow=0.
- Secure privilege: write 0xDEADBEEF with secure=1, pop with rd_priv=0 -> rd_data=0, rd_secure=1, sec_violation=1. Repeat with rd_priv=1 -> rd_data=0xDEADBEEF, no violation.
- Simultaneous write and pop: while full, strobe 0x55 together with rd_req -> count stays 8, overflow=0. While empty, same stimulus -> count=1, rd_valid=0.
- Async reset mid-stream: rst1=0 between clk edges with count=5 -> count=0, empty=1, rd_valid=0 immediately. After release, a write of 0x77 then a pop returns 0x77.
- status_in=0: strobe 0x99 -> count unchanged, overflow=0. With SEC_FLUSH_ON_VIOLATION_EN defined, a violating pop with 3 entries left -> empty=1 two cycles later.
